// File: rtl/clk_div_pkg.sv
// Shared constants and types for the programmable clock divider.
//   DIV_WIDTH   : default divisor/counter width
//   MIN_DIV     : smallest divisor accepted; smaller loads are clamped to this
//   DEFAULT_DIV : divisor in effect after reset
//   div_t       : divisor-sized vector so neighbouring blocks size registers consistently
package clk_div_pkg;

    localparam int unsigned DIV_WIDTH   = 16;
    localparam int unsigned MIN_DIV     = 2;
    localparam int unsigned DEFAULT_DIV = 4;

    typedef logic [DIV_WIDTH-1:0] div_t;

endpackage

// File: rtl/clk_divider.sv
// Programmable synchronous clock divider and tick generator.
// Produces a registered square wave (clk_out) and a one-cycle strobe (tick) per period.
// The divisor can be reloaded at any time; the new value takes effect only at a period
// boundary, so the output never glitches mid-period.
// Ports:
//   clk      : system clock; all logic runs on its rising edge
//   rst      : synchronous, active-high reset
//   en       : count enable; when low, counter/clk_out/div_cur hold and tick is 0
//   div_in   : new divisor value
//   div_load : single-cycle request to capture div_in
//   clk_out  : divided square wave (data signal, registered)
//   tick     : one-cycle pulse in the first cycle of each period (registered)
//   pend     : a loaded divisor is waiting for the next wrap
//   div_cur  : divisor currently in effect
module clk_divider #(
    parameter int unsigned WIDTH       = clk_div_pkg::DIV_WIDTH,
    parameter int unsigned DEFAULT_DIV = clk_div_pkg::DEFAULT_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] div_in,
    input  logic             div_load,
    output logic             clk_out,
    output logic             tick,
    output logic             pend,
    output logic [WIDTH-1:0] div_cur
);

    import clk_div_pkg::MIN_DIV;

    localparam logic [WIDTH-1:0] DefDiv = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] MinDiv = WIDTH'(MIN_DIV);

    // State
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] pend_val_q, pend_val_d;
    logic             pend_q, pend_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;

    // Combinational helpers
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] lo_d;
    logic             wrap;

    // Divisor to be captured, clamped so the counter always has at least two states.
    assign load_val = (div_in < MinDiv) ? MinDiv : div_in;

    // Last count of the period. div_q >= 2 always, so the subtraction cannot underflow.
    assign wrap = (cnt_q == (div_q - WIDTH'(1)));

    // Low-phase length ceil(div/2) of the divisor in effect for the next cycle;
    // odd divisors put the extra cycle in the low phase.
    assign lo_d = (div_d >> 1) + {{(WIDTH-1){1'b0}}, div_d[0]};

    always_comb begin
        cnt_d      = cnt_q;
        div_d      = div_q;
        pend_val_d = pend_val_q;
        pend_d     = pend_q;
        tick_d     = 1'b0;

        if (en && wrap) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            // A load landing on the wrap edge bypasses the shadow register.
            if (div_load) begin
                div_d  = load_val;
                pend_d = 1'b0;
            end else if (pend_q) begin
                div_d  = pend_val_q;
                pend_d = 1'b0;
            end
        end else begin
            if (en) begin
                cnt_d = cnt_q + WIDTH'(1);
            end
            // Loads are accepted even while disabled; the last one before a wrap wins.
            if (div_load) begin
                pend_val_d = load_val;
                pend_d     = 1'b1;
            end
        end

        // Compare against the updated count so clk_out lines up with cnt_d.
        clk_out_d = en ? (cnt_d >= lo_d) : clk_out_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            div_q      <= DefDiv;
            pend_val_q <= DefDiv;
            pend_q     <= 1'b0;
            clk_out_q  <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            pend_val_q <= pend_val_d;
            pend_q     <= pend_d;
            clk_out_q  <= clk_out_d;
            tick_q     <= tick_d;
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;
    assign pend    = pend_q;
    assign div_cur = div_q;

endmodule

// File: tb/tb_clk_divider.sv
// Directed self-checking bench for clk_divider (default WIDTH=16, DEFAULT_DIV=4).
// Inputs change and outputs are sampled on the falling edge; each expected tuple
// (clk_out, tick, pend, div_cur) is the state after the preceding rising edge.
module tb_clk_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] div_in;
    logic        div_load;
    logic        clk_out;
    logic        tick;
    logic        pend;
    logic [15:0] div_cur;

    int n_tests = 0;
    int n_fail  = 0;
    int step    = 0;

    always #5 clk = ~clk;

    clk_divider dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .div_in   (div_in),
        .div_load (div_load),
        .clk_out  (clk_out),
        .tick     (tick),
        .pend     (pend),
        .div_cur  (div_cur)
    );

    task automatic cyc();
        @(negedge clk);
        step++;
    endtask

    task automatic chk(input string tag, input logic o, input logic t, input logic p,
                       input logic [15:0] d);
        n_tests++;
        assert (clk_out === o) else begin
            n_fail++;
            $error("FAIL %s step %0d clk_out: got %b, expected %b", tag, step, clk_out, o);
        end
        n_tests++;
        assert (tick === t) else begin
            n_fail++;
            $error("FAIL %s step %0d tick: got %b, expected %b", tag, step, tick, t);
        end
        n_tests++;
        assert (pend === p) else begin
            n_fail++;
            $error("FAIL %s step %0d pend: got %b, expected %b", tag, step, pend, p);
        end
        n_tests++;
        assert (div_cur === d) else begin
            n_fail++;
            $error("FAIL %s step %0d div_cur: got %0d, expected %0d", tag, step, div_cur, d);
        end
    endtask

    // Advance one cycle then check.
    task automatic st(input string tag, input logic o, input logic t, input logic p,
                      input logic [15:0] d);
        cyc();
        chk(tag, o, t, p, d);
    endtask

    // Advance n cycles expecting the same state each time.
    task automatic st_n(input int n, input string tag, input logic o, input logic t,
                        input logic p, input logic [15:0] d);
        for (int i = 0; i < n; i++) st(tag, o, t, p, d);
    endtask

    initial begin
        rst      = 1'b1;
        en       = 1'b0;
        div_in   = '0;
        div_load = 1'b0;

        // Reset state
        cyc();
        cyc();
        chk("reset", 1'b0, 1'b0, 1'b0, 16'd4);
        rst = 1'b0;
        en  = 1'b1;

        // Default divisor 4: clk_out 0,0,1,1 ; tick after 4th edge
        for (int k = 0; k < 2; k++) begin
            st("def_c1", 1'b0, 1'b0, 1'b0, 16'd4);
            st("def_c2", 1'b1, 1'b0, 1'b0, 16'd4);
            st("def_c3", 1'b1, 1'b0, 1'b0, 16'd4);
            st("def_wrap", 1'b0, 1'b1, 1'b0, 16'd4);
        end

        // Odd divisor 5 loaded just after a wrap
        div_load = 1'b1;
        div_in   = 16'd5;
        st("odd_ld", 1'b0, 1'b0, 1'b1, 16'd4);
        div_load = 1'b0;
        st("odd_p2", 1'b1, 1'b0, 1'b1, 16'd4);
        st("odd_p3", 1'b1, 1'b0, 1'b1, 16'd4);
        st("odd_apply", 1'b0, 1'b1, 1'b0, 16'd5);
        for (int k = 0; k < 2; k++) begin
            st_n(2, "odd_lo", 1'b0, 1'b0, 1'b0, 16'd5);
            st_n(2, "odd_hi", 1'b1, 1'b0, 1'b0, 16'd5);
            st("odd_wrap", 1'b0, 1'b1, 1'b0, 16'd5);
        end

        // Last load wins: 7 then 6 before the wrap
        st("lw_c1", 1'b0, 1'b0, 1'b0, 16'd5);
        div_load = 1'b1;
        div_in   = 16'd7;
        st("lw_ld7", 1'b0, 1'b0, 1'b1, 16'd5);
        div_in   = 16'd6;
        st("lw_ld6", 1'b1, 1'b0, 1'b1, 16'd5);
        div_load = 1'b0;
        st("lw_c4", 1'b1, 1'b0, 1'b1, 16'd5);
        st("lw_apply", 1'b0, 1'b1, 1'b0, 16'd6);
        st_n(2, "div6_lo", 1'b0, 1'b0, 1'b0, 16'd6);
        st_n(3, "div6_hi", 1'b1, 1'b0, 1'b0, 16'd6);
        st("div6_wrap", 1'b0, 1'b1, 1'b0, 16'd6);

        // Load coincident with the wrap edge: applied at once, pend never rises
        st_n(2, "co_lo", 1'b0, 1'b0, 1'b0, 16'd6);
        st_n(3, "co_hi", 1'b1, 1'b0, 1'b0, 16'd6);
        div_load = 1'b1;
        div_in   = 16'd3;
        st("co_apply", 1'b0, 1'b1, 1'b0, 16'd3);
        div_load = 1'b0;
        st("div3_c1", 1'b0, 1'b0, 1'b0, 16'd3);
        st("div3_c2", 1'b1, 1'b0, 1'b0, 16'd3);
        st("div3_wrap", 1'b0, 1'b1, 1'b0, 16'd3);

        // Clamp: loads of 0 then 1 give divisor 2
        div_load = 1'b1;
        div_in   = 16'd0;
        st("clamp_ld0", 1'b0, 1'b0, 1'b1, 16'd3);
        div_in   = 16'd1;
        st("clamp_ld1", 1'b1, 1'b0, 1'b1, 16'd3);
        div_load = 1'b0;
        st("clamp_apply", 1'b0, 1'b1, 1'b0, 16'd2);
        for (int k = 0; k < 2; k++) begin
            st("div2_hi", 1'b1, 1'b0, 1'b0, 16'd2);
            st("div2_wrap", 1'b0, 1'b1, 1'b0, 16'd2);
        end

        // Enable gating in the high phase; load while disabled stays pending
        div_load = 1'b1;
        div_in   = 16'd4;
        st("eg_ld4", 1'b1, 1'b0, 1'b1, 16'd2);
        div_load = 1'b0;
        st("eg_apply4", 1'b0, 1'b1, 1'b0, 16'd4);
        st("eg_c1", 1'b0, 1'b0, 1'b0, 16'd4);
        st("eg_c2", 1'b1, 1'b0, 1'b0, 16'd4);
        en       = 1'b0;
        div_load = 1'b1;
        div_in   = 16'd8;
        st("eg_stall1", 1'b1, 1'b0, 1'b1, 16'd4);
        div_load = 1'b0;
        st_n(2, "eg_stall", 1'b1, 1'b0, 1'b1, 16'd4);
        en = 1'b1;
        st("eg_c3", 1'b1, 1'b0, 1'b1, 16'd4);
        st("eg_apply8", 1'b0, 1'b1, 1'b0, 16'd8);

        // Stall on the last count: no wrap and no tick until enabled again
        st_n(3, "div8_lo", 1'b0, 1'b0, 1'b0, 16'd8);
        st_n(4, "div8_hi", 1'b1, 1'b0, 1'b0, 16'd8);
        en = 1'b0;
        st("stall_last", 1'b1, 1'b0, 1'b0, 16'd8);
        en = 1'b1;
        st("div8_wrap", 1'b0, 1'b1, 1'b0, 16'd8);

        // Reach cnt=3, div_cur=9, pend=1, then reset
        div_load = 1'b1;
        div_in   = 16'd9;
        st("r_ld9", 1'b0, 1'b0, 1'b1, 16'd8);
        div_load = 1'b0;
        st_n(2, "r_lo", 1'b0, 1'b0, 1'b1, 16'd8);
        st_n(4, "r_hi", 1'b1, 1'b0, 1'b1, 16'd8);
        st("r_apply9", 1'b0, 1'b1, 1'b0, 16'd9);
        div_load = 1'b1;
        div_in   = 16'd5;
        st("r_ld5", 1'b0, 1'b0, 1'b1, 16'd9);
        div_load = 1'b0;
        st_n(2, "r_cnt3", 1'b0, 1'b0, 1'b1, 16'd9);
        rst = 1'b1;
        st("mid_reset", 1'b0, 1'b0, 1'b0, 16'd4);
        rst = 1'b0;
        st("rs_c1", 1'b0, 1'b0, 1'b0, 16'd4);
        st("rs_c2", 1'b1, 1'b0, 1'b0, 16'd4);
        st("rs_c3", 1'b1, 1'b0, 1'b0, 16'd4);
        st("rs_wrap", 1'b0, 1'b1, 1'b0, 16'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
